pwm_duty_ctrl: RTL and testbench
================================

# pwm_duty_ctrl

Upstream stage of the 8-bit PWM generator: produces the duty value that the generator's duty register loads and compares against its 256-step counter. Two modes: manual, where debounced up/down keys step the duty with saturation, and breathe, where the duty ramps up and down as a triangle wave. The duty output changes only on a PWM period boundary, so the comparator never sees a mid-period change.

## Interface

- WIDTH, 8, duty width; MAX = 2^WIDTH-1
- STEP, 16, duty increment per press or per breathe step (1..MAX)
- DEB_CYCLES, 20, consecutive stable cycles required to accept a key level (≥1)
- HOLD, 4, PWM periods per breathe step (≥1)

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- key_up  in  1  raw asynchronous push-button, active-high
- key_down  in  1  raw asynchronous push-button, active-high
- mode  in  1  0 = manual, 1 = breathe
- period_tick  in  1  one-cycle pulse from the PWM counter at wrap (count MAX→0)
- duty  out  WIDTH  duty value for the PWM duty register
- duty_valid  out  1  one-cycle pulse in the first cycle a changed duty is visible
- dir  out  1  breathe direction, 1 = rising

## Operation

- Reset values: duty=0, target=0, dir=1, hold_cnt=0, duty_valid=0, debounced key levels=0, debounce counters=0, mode_q=mode.
- Key path, per key: 2-flop synchroniser, then debounce counter. The counter counts consecutive cycles where the synchronised level ≠ the debounced level. It clears on any cycle where they are equal. When it reaches DEB_CYCLES, the debounced level flips and the counter clears. A 0→1 debounced transition emits a one-cycle press pulse. Release emits nothing.
- target register (WIDTH bits) holds the pending duty.
- Saturating arithmetic, for all target updates:
  - up: if target > MAX-STEP, target=MAX; else target+STEP.
  - down: if target < STEP, target=0; else target-STEP.
  - No wrap-around ever.
- Manual mode (mode=0):
  - up press alone → target steps up.
  - down press alone → target steps down.
  - Both presses in the same cycle → no change.
  - On period_tick, duty ← target.
- Breathe mode (mode=1); presses are ignored.
  - On period_tick with hold_cnt < HOLD-1: hold_cnt increments.
  - On period_tick with hold_cnt = HOLD-1: hold_cnt ← 0, target steps in direction dir, duty ← the stepped value in the same edge.
  - Reaching MAX while rising sets dir=0. Reaching 0 while falling sets dir=1.
- Mode change (mode ≠ mode_q) takes priority that cycle: hold_cnt ← 0, dir ← 1, target ← duty, any press is dropped, period_tick is ignored; mode_q ← mode.
- duty_valid is 1 in the cycle after an edge where duty was loaded with a value different from its previous value; otherwise 0.

## Timing

- Key-to-press latency: 2 sync cycles + DEB_CYCLES cycles after the raw level settles. A press pulse updates target on the following edge.
- Press and period_tick in the same cycle (manual): duty loads the pre-press target. The press takes effect at the next period_tick.
- Duty becomes visible one cycle after the edge that samples period_tick=1. duty_valid is high in exactly that cycle.
- Bounce shorter than DEB_CYCLES produces no press.
- A key held indefinitely produces exactly one press.
- rst asserted mid-operation returns all state to reset values on the next edge, regardless of mode or pending ticks.
- The block issues no handshake back to the PWM stage. The PWM stage must sample duty continuously or at wrap.

## Test plan

- Manual step: reset, mode=0, STEP=16, one clean 30-cycle key_up pulse, then period_tick → target=16 at press+1; duty=16 and duty_valid=1 one cycle after the tick; duty stays 0 before the tick.
- Saturation: 17 up presses with ticks between them → duty sequence 16…240, then 255, 255. From 0, a down press → duty remains 0 and duty_valid stays 0.
- Debounce: key_up toggling every 5 cycles for 100 cycles with DEB_CYCLES=20 → no press. Key held 500 cycles → exactly one press.
- Simultaneous: key_up and key_down debounced in the same cycle → target unchanged. A press coincident with period_tick → duty takes the new value only on the following tick.
- Breathe: mode=1, HOLD=4, period_tick every 256 cycles → duty steps every 4th tick: 16, 32, …, 240, 255 (dir→0), 239, …, 15, 0 (dir→1), 16. duty_valid pulses once per step.
- Mode switch and reset: switch to breathe at duty=100 → ramp continues upward from 100 (116, …). Assert rst mid-ramp → duty=0, dir=1, duty_valid=0 on the next cycle.

Source files
------------

// File: rtl/pwm_duty_ctrl.sv
// Duty-value source for the 8-bit PWM generator: debounced manual stepping or triangle "breathe" ramp,
// with the duty output updated only on PWM period boundaries.
module pwm_duty_ctrl #(
    parameter int WIDTH      = 8,
    parameter int STEP       = 16,
    parameter int DEB_CYCLES = 20,
    parameter int HOLD       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_up,
    input  logic             key_down,
    input  logic             mode,
    input  logic             period_tick,
    output logic [WIDTH-1:0] duty,
    output logic             duty_valid,
    output logic             dir
);

    localparam logic [WIDTH-1:0] MAX       = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] STEP_V    = WIDTH'(STEP);
    localparam int               DEB_W     = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam int               HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

    function automatic logic [WIDTH-1:0] sat_up(input logic [WIDTH-1:0] v);
        return (v > MAX - STEP_V) ? MAX : v + STEP_V;
    endfunction

    function automatic logic [WIDTH-1:0] sat_down(input logic [WIDTH-1:0] v);
        return (v < STEP_V) ? '0 : v - STEP_V;
    endfunction

    // Key index 0 = up, 1 = down
    logic [1:0]            raw_keys;
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            deb_q, deb_d;
    logic [1:0]            press_q, press_d;
    logic [1:0][DEB_W-1:0] cnt_q, cnt_d;

    assign raw_keys = {key_down, key_up};

    // A level is accepted only after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        deb_d   = deb_q;
        press_d = '0;
        cnt_d   = '0;
        for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] != deb_q[k]) begin
                if (cnt_q[k] == DEB_LAST) begin
                    deb_d[k]   = sync2_q[k];
                    press_d[k] = sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + DEB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            press_q <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_keys;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [WIDTH-1:0]  duty_q, duty_d;
    logic [WIDTH-1:0]  target_q, target_d;
    logic              dir_q, dir_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              valid_q, valid_d;
    logic              mode_q;
    logic              up_press, down_press;
    logic [WIDTH-1:0]  stepped;

    assign up_press   = press_q[0] & ~press_q[1];
    assign down_press = press_q[1] & ~press_q[0];
    assign stepped    = dir_q ? sat_up(target_q) : sat_down(target_q);

    always_comb begin
        duty_d   = duty_q;
        target_d = target_q;
        dir_d    = dir_q;
        hold_d   = hold_q;
        if (mode != mode_q) begin
            // Restart cleanly from whatever the PWM is currently showing.
            hold_d   = '0;
            dir_d    = 1'b1;
            target_d = duty_q;
        end else if (!mode_q) begin
            if (up_press) begin
                target_d = sat_up(target_q);
            end else if (down_press) begin
                target_d = sat_down(target_q);
            end
            if (period_tick) begin
                duty_d = target_q;
            end
        end else if (period_tick) begin
            if (hold_q != HOLD_LAST) begin
                hold_d = hold_q + HOLD_W'(1);
            end else begin
                hold_d   = '0;
                target_d = stepped;
                duty_d   = stepped;
                if (dir_q && stepped == MAX) begin
                    dir_d = 1'b0;
                end else if (!dir_q && stepped == '0) begin
                    dir_d = 1'b1;
                end
            end
        end
        valid_d = (duty_d != duty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q   <= '0;
            target_q <= '0;
            dir_q    <= 1'b1;
            hold_q   <= '0;
            valid_q  <= 1'b0;
            mode_q   <= mode;
        end else begin
            duty_q   <= duty_d;
            target_q <= target_d;
            dir_q    <= dir_d;
            hold_q   <= hold_d;
            valid_q  <= valid_d;
            mode_q   <= mode;
        end
    end

    assign duty       = duty_q;
    assign duty_valid = valid_q;
    assign dir        = dir_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl: manual stepping, saturation, debounce, simultaneous keys,
// breathe ramp, mode switch and mid-ramp reset.
module tb_pwm_duty_ctrl;

    localparam int WIDTH = 8;
    localparam int HOLD  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             key_up = 1'b0;
    logic             key_down = 1'b0;
    logic             mode = 1'b0;
    logic             period_tick = 1'b0;
    logic [WIDTH-1:0] duty;
    logic             duty_valid;
    logic             dir;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_duty_ctrl #(.WIDTH(WIDTH), .STEP(16), .DEB_CYCLES(20), .HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down), .mode(mode),
        .period_tick(period_tick), .duty(duty), .duty_valid(duty_valid), .dir(dir)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press_up();
        key_up = 1'b1;
        cyc(30);
        key_up = 1'b0;
        cyc(30);
    endtask

    task automatic press_down();
        key_down = 1'b1;
        cyc(30);
        key_down = 1'b0;
        cyc(30);
    endtask

    task automatic pulse_tick();
        period_tick = 1'b1;
        cyc(1);
        period_tick = 1'b0;
        cyc(3);
    endtask

    task automatic tick_chk(input string tag, input int exp_duty, input bit exp_valid);
        period_tick = 1'b1;
        cyc(1);
        period_tick = 1'b0;
        chk({tag, "_duty"}, 32'(duty), 32'(exp_duty));
        chk({tag, "_valid"}, 32'(duty_valid), 32'(exp_valid));
        cyc(1);
        chk({tag, "_valid_off"}, 32'(duty_valid), 0);
        cyc(2);
    endtask

    task automatic bstep(input string tag, input int exp_duty);
        repeat (HOLD - 1) pulse_tick();
        tick_chk(tag, exp_duty, 1'b1);
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("reset_duty", 32'(duty), 0);
        chk("reset_valid", 32'(duty_valid), 0);
        chk("reset_dir", 32'(dir), 1);

        // Manual step: duty holds until the tick
        key_up = 1'b1;
        cyc(30);
        key_up = 1'b0;
        chk("pre_tick_duty", 32'(duty), 0);
        cyc(30);
        chk("pre_tick_duty2", 32'(duty), 0);
        tick_chk("step1", 16, 1'b1);

        // Saturation upward
        for (int i = 2; i <= 15; i++) begin
            press_up();
            tick_chk($sformatf("up%0d", i), 16 * i, 1'b1);
        end
        press_up();
        tick_chk("sat_255", 255, 1'b1);
        press_up();
        tick_chk("sat_hold", 255, 1'b0);

        // Saturation downward from zero
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst2_duty", 32'(duty), 0);
        press_down();
        tick_chk("down_floor", 0, 1'b0);

        // Bounce shorter than the debounce window
        for (int i = 0; i < 20; i++) begin
            key_up = ~key_up;
            cyc(5);
        end
        key_up = 1'b0;
        cyc(30);
        tick_chk("bounce", 0, 1'b0);

        // Long hold gives exactly one press
        key_up = 1'b1;
        cyc(500);
        key_up = 1'b0;
        cyc(30);
        tick_chk("hold_once", 16, 1'b1);
        tick_chk("hold_once2", 16, 1'b0);

        // Both keys in the same cycle cancel
        key_up   = 1'b1;
        key_down = 1'b1;
        cyc(30);
        key_up   = 1'b0;
        key_down = 1'b0;
        cyc(30);
        tick_chk("both_keys", 16, 1'b0);

        // Press pulse coincident with the tick: duty gets the pre-press target
        key_up = 1'b1;
        cyc(22);
        period_tick = 1'b1;
        cyc(1);
        period_tick = 1'b0;
        chk("coinc_duty", 32'(duty), 16);
        chk("coinc_valid", 32'(duty_valid), 0);
        cyc(10);
        key_up = 1'b0;
        cyc(30);
        tick_chk("coinc_next", 32, 1'b1);

        // Switch to breathe: ramp continues upward from the current duty
        mode = 1'b1;
        cyc(1);
        chk("switch_duty", 32'(duty), 32);
        chk("switch_dir", 32'(dir), 1);
        for (int v = 48; v <= 240; v += 16) bstep($sformatf("rise%0d", v), v);
        press_up();
        bstep("peak", 255);
        chk("peak_dir", 32'(dir), 0);
        for (int v = 239; v >= 15; v -= 16) bstep($sformatf("fall%0d", v), v);
        bstep("floor", 0);
        chk("floor_dir", 32'(dir), 1);
        bstep("rebound", 16);

        // Reset mid-ramp, coincident with a tick
        pulse_tick();
        pulse_tick();
        rst = 1'b1;
        period_tick = 1'b1;
        cyc(1);
        rst = 1'b0;
        period_tick = 1'b0;
        chk("midrst_duty", 32'(duty), 0);
        chk("midrst_valid", 32'(duty_valid), 0);
        chk("midrst_dir", 32'(dir), 1);
        bstep("post_rst", 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
